// File: rtl/lemonpc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lemonpc_pkg : shared LemonPC core widths, index type and constants   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lemonpc_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 64;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

   localparam int REG_ZERO = 0;
endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_scoreboard_if : read, write and issue bundle of the regfile  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface regfile_scoreboard_if
   import lemonpc_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int DATA_WIDTH = XLEN,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 1
);
   logic [NUM_READ*ADDR_WIDTH-1:0]  raddr;
   logic [NUM_READ*DATA_WIDTH-1:0]  rdata;
   logic [NUM_READ-1:0]             rbusy;
   logic [NUM_WRITE-1:0]            wen;
   logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr;
   logic [NUM_WRITE*DATA_WIDTH-1:0] wdata;
   logic                            issue_valid;
   logic [ADDR_WIDTH-1:0]           issue_rd;
   logic                            issue_ready;
   logic [ADDR_WIDTH:0]             busy_count;

   modport master (
      output raddr, wen, waddr, wdata, issue_valid, issue_rd,
      input  rdata, rbusy, issue_ready, busy_count
   );

   modport slave (
      input  raddr, wen, waddr, wdata, issue_valid, issue_rd,
      output rdata, rbusy, issue_ready, busy_count
   );
endinterface
`default_nettype wire

// File: rtl/rf_bypass_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_bypass_mux : per read port write-forwarding select and x0 masking |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rf_bypass_mux
   import lemonpc_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int DATA_WIDTH = XLEN,
   parameter int NUM_WRITE  = 1,
   parameter int BYPASS     = 1
)(
   input  logic [ADDR_WIDTH-1:0]           i_raddr,
   input  logic [DATA_WIDTH-1:0]           i_stored_data,
   input  logic                            i_stored_busy,
   input  logic [NUM_WRITE-1:0]            i_wen,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0] i_waddr,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0]           o_rdata,
   output logic                            o_rbusy
);
   localparam logic [ADDR_WIDTH-1:0] c_zero = ADDR_WIDTH'(REG_ZERO);

   logic                  w_hit;
   logic [DATA_WIDTH-1:0] w_data;

   generate
      if (BYPASS != 0) begin : g_bypass
         // Later ports overwrite earlier ones, so the highest-numbered writer wins.
         always_comb begin
            w_hit  = 1'b0;
            w_data = i_stored_data;
            for (int j = 0; j < NUM_WRITE; j++) begin
               if (i_wen[j] && (i_waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == i_raddr)) begin
                  w_hit  = 1'b1;
                  w_data = i_wdata[j*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end else begin : g_no_bypass
         logic w_unused;
         assign w_unused = ^{i_wen, i_waddr, i_wdata};
         assign w_hit    = 1'b0;
         assign w_data   = i_stored_data;
      end
   endgenerate

   always_comb begin
      o_rdata = w_data;
      o_rbusy = i_stored_busy && !w_hit;
      if (i_raddr == c_zero) begin
         o_rdata = '0;
         o_rbusy = 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_scoreboard : multi-port integer regfile with busy scoreboard |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_scoreboard
   import lemonpc_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int DATA_WIDTH = XLEN,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 1,
   parameter int BYPASS     = 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_scoreboard_if.slave  bus
);
   localparam int                    c_nregs = 2**ADDR_WIDTH;
   localparam int                    c_cw    = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] c_zero  = ADDR_WIDTH'(REG_ZERO);

   logic [DATA_WIDTH-1:0] r_regs [c_nregs];
   logic [c_nregs-1:0]    r_busy;
   logic [c_cw-1:0]       r_count;

   logic [c_nregs-1:0]    w_clr;
   logic [c_nregs-1:0]    w_busy_next;
   logic [c_cw-1:0]       w_count_next;
   logic                  w_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_nregs; i++) r_regs[i] <= '0;
      end else begin
         for (int j = 0; j < NUM_WRITE; j++) begin
            if (bus.wen[j] && (bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != c_zero))
               r_regs[bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_clr = '0;
      for (int j = 0; j < NUM_WRITE; j++) begin
         if (bus.wen[j]) w_clr[bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
   end

   assign bus.issue_ready = (bus.issue_rd == c_zero) || !r_busy[bus.issue_rd] ||
                            ((BYPASS != 0) && w_clr[bus.issue_rd]);
   assign w_set = bus.issue_valid && bus.issue_ready && (bus.issue_rd != c_zero);

   // A set landing on an index being cleared keeps it busy: a new producer is in flight.
   always_comb begin
      w_busy_next = r_busy & ~w_clr;
      if (w_set) w_busy_next[bus.issue_rd] = 1'b1;
      w_busy_next[0] = 1'b0;
      w_count_next = '0;
      for (int i = 0; i < c_nregs; i++) w_count_next = w_count_next + c_cw'(w_busy_next[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_count <= '0;
      end else begin
         r_busy  <= w_busy_next;
         r_count <= w_count_next;
      end
   end

   assign bus.busy_count = r_count;

   generate
      for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
         logic [ADDR_WIDTH-1:0] w_raddr;
         assign w_raddr = bus.raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

         rf_bypass_mux #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WRITE  (NUM_WRITE),
            .BYPASS     (BYPASS)
         ) u_mux (
            .i_raddr       (w_raddr),
            .i_stored_data (r_regs[w_raddr]),
            .i_stored_busy (r_busy[w_raddr]),
            .i_wen         (bus.wen),
            .i_waddr       (bus.waddr),
            .i_wdata       (bus.wdata),
            .o_rdata       (bus.rdata[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_rbusy       (bus.rbusy[k])
         );
      end
   endgenerate
endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_scoreboard : bypass/two-writer and no-bypass instances    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regfile_scoreboard;
   import lemonpc_pkg::*;

   localparam int AW = 5;
   localparam int DW = 64;
   localparam int F_RDATA = 0, F_RBUSY = 1, F_READY = 2, F_COUNT = 3;

   typedef struct {
      string       name;
      int          dut;
      int          field;
      int          port;
      logic [63:0] exp;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(2), .NUM_WRITE(2)) if1 ();
   regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(2), .NUM_WRITE(1)) if0 ();

   regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(2), .NUM_WRITE(1), .BYPASS(0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

   exp_t        sb_q [$];
   exp_t        mon_e;
   logic [63:0] mon_a;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic idle();
      if1.raddr = '0; if1.wen = '0; if1.waddr = '0; if1.wdata = '0;
      if1.issue_valid = 1'b0; if1.issue_rd = '0;
      if0.raddr = '0; if0.wen = '0; if0.waddr = '0; if0.wdata = '0;
      if0.issue_valid = 1'b0; if0.issue_rd = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic rd(input int d, input int p, input int a);
      if (d == 1) if1.raddr[p*AW +: AW] = AW'(a);
      else        if0.raddr[p*AW +: AW] = AW'(a);
   endtask

   task automatic wr(input int d, input int p, input int a, input logic [63:0] v);
      if (d == 1) begin
         if1.wen[p] = 1'b1; if1.waddr[p*AW +: AW] = AW'(a); if1.wdata[p*DW +: DW] = v;
      end else begin
         if0.wen[p] = 1'b1; if0.waddr[p*AW +: AW] = AW'(a); if0.wdata[p*DW +: DW] = v;
      end
   endtask

   task automatic iss(input int d, input int a, input logic v);
      if (d == 1) begin if1.issue_valid = v; if1.issue_rd = AW'(a); end
      else        begin if0.issue_valid = v; if0.issue_rd = AW'(a); end
   endtask

   task automatic chk(input string n, input int d, input int f, input int p, input logic [63:0] e);
      sb_q.push_back('{n, d, f, p, e});
   endtask

   function automatic logic [63:0] actual(input int d, input int f, input int p);
      if (d == 1) begin
         case (f)
            F_RDATA: return if1.rdata[p*DW +: DW];
            F_RBUSY: return 64'(if1.rbusy[p]);
            F_READY: return 64'(if1.issue_ready);
            default: return 64'(if1.busy_count);
         endcase
      end else begin
         case (f)
            F_RDATA: return if0.rdata[p*DW +: DW];
            F_RBUSY: return 64'(if0.rbusy[p]);
            F_READY: return 64'(if0.issue_ready);
            default: return 64'(if0.busy_count);
         endcase
      end
   endfunction

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         mon_a = actual(mon_e.dut, mon_e.field, mon_e.port);
         n_cmp++;
         if (mon_a !== mon_e.exp) begin
            n_err++;
            $display("FAIL %s dut%0d port%0d: got 0x%0h, expected 0x%0h",
                     mon_e.name, mon_e.dut, mon_e.port, mon_a, mon_e.exp);
         end
      end
   end

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 32; i++) begin
         step();
         rd(1, 0, i); rd(1, 1, 31 - i); rd(0, 0, i);
         chk("rst_rdata0", 1, F_RDATA, 0, 64'h0);
         chk("rst_rdata1", 1, F_RDATA, 1, 64'h0);
         chk("rst_rbusy0", 1, F_RBUSY, 0, 64'h0);
         chk("rst_rbusy1", 1, F_RBUSY, 1, 64'h0);
         chk("rst_rdata_nb", 0, F_RDATA, 0, 64'h0);
         chk("rst_count", 1, F_COUNT, 0, 64'h0);
      end

      // x0 is never written and never forwarded
      step(); wr(1, 0, 0, 64'hDEAD); wr(0, 0, 0, 64'hDEAD); rd(1, 0, 0); rd(0, 0, 0);
      chk("x0_same_cycle", 1, F_RDATA, 0, 64'h0);
      step(); rd(1, 0, 0); rd(0, 0, 0);
      chk("x0_after", 1, F_RDATA, 0, 64'h0);
      chk("x0_after_nb", 0, F_RDATA, 0, 64'h0);

      step(); wr(1, 0, 5, 64'h1234); wr(0, 0, 5, 64'h1234); rd(1, 0, 5); rd(0, 0, 5);
      chk("bypass_x5", 1, F_RDATA, 0, 64'h1234);
      chk("nobypass_x5_old", 0, F_RDATA, 0, 64'h0);
      step(); rd(1, 0, 5); rd(0, 0, 5);
      chk("x5_stored", 1, F_RDATA, 0, 64'h1234);
      chk("x5_stored_nb", 0, F_RDATA, 0, 64'h1234);

      // issue x7, WAW stall, then writeback
      step(); iss(1, 7, 1'b1); iss(0, 7, 1'b1);
      chk("iss7_ready", 1, F_READY, 0, 64'h1);
      chk("iss7_ready_nb", 0, F_READY, 0, 64'h1);
      step(); iss(1, 7, 1'b1); iss(0, 7, 1'b1); rd(1, 0, 7); rd(0, 0, 7);
      chk("x7_rbusy", 1, F_RBUSY, 0, 64'h1);
      chk("x7_rbusy_nb", 0, F_RBUSY, 0, 64'h1);
      chk("x7_count", 1, F_COUNT, 0, 64'h1);
      chk("x7_count_nb", 0, F_COUNT, 0, 64'h1);
      chk("x7_waw_stall", 1, F_READY, 0, 64'h0);
      chk("x7_waw_stall_nb", 0, F_READY, 0, 64'h0);
      step(); wr(1, 0, 7, 64'h77); wr(0, 0, 7, 64'h77); rd(1, 1, 7); rd(0, 1, 7);
      iss(1, 7, 1'b0); iss(0, 7, 1'b0);
      chk("x7_wb_ready", 1, F_READY, 0, 64'h1);
      chk("x7_wb_rbusy", 1, F_RBUSY, 1, 64'h0);
      chk("x7_wb_rdata", 1, F_RDATA, 1, 64'h77);
      chk("x7_wb_ready_nb", 0, F_READY, 0, 64'h0);
      chk("x7_wb_rbusy_nb", 0, F_RBUSY, 1, 64'h1);
      chk("x7_wb_rdata_nb", 0, F_RDATA, 1, 64'h0);
      step(); rd(1, 0, 7); rd(0, 0, 7);
      chk("x7_clr_count", 1, F_COUNT, 0, 64'h0);
      chk("x7_clr_count_nb", 0, F_COUNT, 0, 64'h0);
      chk("x7_clr_rbusy", 1, F_RBUSY, 0, 64'h0);
      chk("x7_clr_rdata", 1, F_RDATA, 0, 64'h77);
      chk("x7_clr_rdata_nb", 0, F_RDATA, 0, 64'h77);

      // re-issue x9 in the same cycle as its writeback
      step(); iss(1, 9, 1'b1);
      chk("iss9_ready", 1, F_READY, 0, 64'h1);
      step(); iss(1, 9, 1'b1); wr(1, 0, 9, 64'h99); rd(1, 0, 9);
      chk("x9_collide_ready", 1, F_READY, 0, 64'h1);
      chk("x9_collide_count", 1, F_COUNT, 0, 64'h1);
      chk("x9_collide_rbusy", 1, F_RBUSY, 0, 64'h0);
      chk("x9_collide_rdata", 1, F_RDATA, 0, 64'h99);
      step(); rd(1, 0, 9);
      chk("x9_after_rdata", 1, F_RDATA, 0, 64'h99);
      chk("x9_after_rbusy", 1, F_RBUSY, 0, 64'h1);
      chk("x9_after_count", 1, F_COUNT, 0, 64'h1);
      step(); wr(1, 1, 9, 64'h100);
      chk("x9_wb2_count", 1, F_COUNT, 0, 64'h1);
      step(); rd(1, 0, 9);
      chk("x9_final_count", 1, F_COUNT, 0, 64'h0);
      chk("x9_final_rdata", 1, F_RDATA, 0, 64'h100);

      // both write ports hit x3: port 1 wins
      step(); wr(1, 0, 3, 64'hA); wr(1, 1, 3, 64'hB); rd(1, 0, 3);
      chk("dual_wr_bypass", 1, F_RDATA, 0, 64'hB);
      step(); rd(1, 0, 3); rd(1, 1, 5);
      chk("dual_wr_stored", 1, F_RDATA, 0, 64'hB);
      chk("x5_retained", 1, F_RDATA, 1, 64'h1234);

      for (int i = 1; i < 32; i++) begin
         step(); iss(1, i, 1'b1);
         chk("fill_ready", 1, F_READY, 0, 64'h1);
         chk("fill_count", 1, F_COUNT, 0, 64'(i - 1));
      end
      step(); rd(1, 0, 31); iss(1, 31, 1'b1);
      chk("full_count", 1, F_COUNT, 0, 64'd31);
      chk("full_rbusy", 1, F_RBUSY, 0, 64'h1);
      chk("full_stall", 1, F_READY, 0, 64'h0);

      // asynchronous reset mid-cycle clears state before any edge
      step(); rd(1, 0, 5); rd(1, 1, 3); rd(0, 0, 7); rst_n = 1'b0;
      chk("arst_count", 1, F_COUNT, 0, 64'h0);
      chk("arst_rdata0", 1, F_RDATA, 0, 64'h0);
      chk("arst_rdata1", 1, F_RDATA, 1, 64'h0);
      chk("arst_rbusy1", 1, F_RBUSY, 1, 64'h0);
      chk("arst_rdata_nb", 0, F_RDATA, 0, 64'h0);
      step(); rst_n = 1'b1; rd(1, 0, 3); rd(1, 1, 31);
      chk("post_rst_rdata", 1, F_RDATA, 0, 64'h0);
      chk("post_rst_rbusy", 1, F_RBUSY, 1, 64'h0);
      chk("post_rst_count", 1, F_COUNT, 0, 64'h0);
      step();
      chk("post_rst_ready", 1, F_READY, 0, 64'h1);
      chk("post_rst_count2", 1, F_COUNT, 0, 64'h0);

      @(negedge clk);
      #1;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-port integer register file for the LemonPC core, combined with a per-register busy scoreboard for the pipelined datapath. It supports NUM_READ asynchronous read ports and NUM_WRITE synchronous write ports, with optional same-cycle write-to-read bypass. Register x0 is hardwired to zero. An issue port marks destination registers busy and writeback clears them, so the decode stage can detect RAW and WAW hazards.

Parameters:
ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
DATA_WIDTH, 64, register width in bits.
NUM_READ, 2, number of read ports (1..4).
NUM_WRITE, 1, number of write ports (1..2).
BYPASS, 1, 1 = a same-cycle write is forwarded to reads; 0 = a write is visible only from the next cycle.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous reset, active low
raddr  in  NUM_READ*ADDR_WIDTH  read indices; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  NUM_READ*DATA_WIDTH  read data for each port (combinational)
rbusy  out  NUM_READ  per-port flag: the source register still has an outstanding producer
wen  in  NUM_WRITE  write enable for each write port
waddr  in  NUM_WRITE*ADDR_WIDTH  write indices
wdata  in  NUM_WRITE*DATA_WIDTH  write data
issue_valid  in  1  the decode stage issues an instruction that writes issue_rd
issue_rd  in  ADDR_WIDTH  destination index of the issued instruction
issue_ready  out  1  high when issue_rd may be marked busy
busy_count  out  ADDR_WIDTH+1  number of registers currently busy

Behaviour:
- Reset (rst_n low, asynchronous): all entries are 0, all busy bits are 0, busy_count=0. Outputs then follow the combinational rules with zero state.
- x0: reads always return 0 and rbusy=0; writes to index 0 are ignored; issue to index 0 never sets busy; issue_ready=1 whenever issue_rd=0.
- Write: at the rising edge, entry waddr[j] <= wdata[j] when wen[j]=1.
- Simultaneous writes to the same index: the highest-numbered port wins, for both storage and bypass.
- Read: rdata[k] is the stored value of raddr[k], with no clock latency.
- BYPASS=1: if any enabled write port targets raddr[k] (nonzero) this cycle, rdata[k] returns that wdata, using the highest-index port.
- Busy bits:
  - Set at the edge when issue_valid && issue_ready && issue_rd != 0.
  - Cleared at the edge when any enabled write targets that index.
  - If set and clear hit the same index in one cycle, set wins (a new producer is in flight).
- rbusy[k] = busy[raddr[k]], except that with BYPASS=1 it reads 0 when a same-cycle write targets raddr[k].
- issue_ready = !busy[issue_rd] (WAW stall). With BYPASS=1, a same-cycle write to issue_rd also makes issue_ready=1.
- issue_valid while issue_ready=0 has no effect. The stage must hold issue_valid and issue_rd until issue_ready is seen high; no internal queue.
- busy_count is a registered counter, updated each edge by (+1 on set) (−1 per distinct cleared busy index, excluding an index that is set the same cycle). It must always equal the popcount of the busy bits; the maximum value is 2**ADDR_WIDTH−1.
- Writes to non-busy registers are legal (e.g. CSR or debug writes); the data is stored and busy stays 0.
- Reset asserted mid-operation discards all pending busy state immediately; no writes complete after rst_n falls.
- Simulation only (translate_off): on every edge with any wen, $display "x%0d: 0x%0x -> 0x%0x" for each register whose value changes.

Decomposition:
- Shared package lemonpc_pkg:
  - REG_ADDR_W=5 and XLEN=64 defaults.
  - typedef reg_idx_t for register indices.
  - constant REG_ZERO=0.
- One sub-module: rf_bypass_mux, per read port. It performs the write-port priority select and x0 masking, and produces the bypassed rdata and rbusy. Storage and scoreboard stay in the top.

Test Plan:
- Reset, then read x0..x31 on both ports -> all rdata=0, rbusy=0, busy_count=0; a write of 0xDEAD to x0 followed by a read of x0 -> 0.
- Write x5=0x1234 (BYPASS=1) with raddr0=5 in the same cycle -> rdata0=0x1234 that cycle. Repeat with BYPASS=0 -> old value 0 that cycle and 0x1234 on the next cycle.
- Issue rd=7 -> next cycle rbusy=1 for raddr=7, busy_count=1, and issue_ready=0 for a second issue to 7. A write to x7 clears busy and busy_count returns to 0.
- Same cycle: issue rd=9 while x9 is busy and its writeback occurs -> issue_ready=1 (BYPASS=1). After the edge, x9 holds the written value, busy[9] stays 1, and busy_count is unchanged.
- NUM_WRITE=2, both ports write x3 (0xA on port 0, 0xB on port 1) -> x3=0xB, and the bypassed read returns 0xB.
- Issue x1..x31 over 31 cycles -> busy_count=31. Pulse rst_n low mid-sequence -> all busy bits and data are 0 immediately, and busy_count=0.
